// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status controller for an asynchronous FIFO.
// Optional macro WPTR_LEVEL_EN adds the read-pointer decoder, W_LEVEL and ALMOST_FULL.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2
) (
  input  logic                  W_CLK,
  input  logic                  WRST_n,
  input  logic                  W_EN,
  input  logic                  CLR_OVF,
  input  logic [ADDR_WIDTH:0]   G_RPTR_SYNC,
  output logic                  W_ACCEPT,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   G_WPTR,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] b_wptr_q, b_wptr_d;
  logic [PTR_WIDTH-1:0] g_wptr_q, g_wptr_d;
  logic [PTR_WIDTH-1:0] g_full_cmp;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;

  assign W_ACCEPT = W_EN & ~full_q;

  // Full when our next Gray pointer equals the read pointer with the top two bits inverted.
  assign g_full_cmp = {~G_RPTR_SYNC[PTR_WIDTH-1:PTR_WIDTH-2], G_RPTR_SYNC[PTR_WIDTH-3:0]};

  always_comb begin
    b_wptr_d = b_wptr_q + {{(PTR_WIDTH-1){1'b0}}, W_ACCEPT};
    g_wptr_d = (b_wptr_d >> 1) ^ b_wptr_d;
    full_d   = (g_wptr_d == g_full_cmp);
    ovf_d    = (W_EN & full_q) | (ovf_q & ~CLR_OVF);
  end

  always_ff @(posedge W_CLK or negedge WRST_n) begin
    if (!WRST_n) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign W_ADDR   = b_wptr_q[ADDR_WIDTH-1:0];
  assign G_WPTR   = g_wptr_q;
  assign FULL     = full_q;
  assign OVERFLOW = ovf_q;

`ifdef WPTR_LEVEL_EN
  localparam int                   AFW   = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0]   AF_T  = AFW'(AF_THRESH);

  logic [PTR_WIDTH-1:0] r_bin;
  logic [PTR_WIDTH-1:0] level_q, level_d;
  logic                 af_q, af_d;

  for (genvar gi = 0; gi < PTR_WIDTH; gi++) begin : g_gray2bin
    assign r_bin[gi] = ^G_RPTR_SYNC[PTR_WIDTH-1:gi];
  end

  always_comb begin
    level_d = b_wptr_d - r_bin;
    af_d    = ({1'b0, level_d} >= AF_T);
  end

  always_ff @(posedge W_CLK or negedge WRST_n) begin
    if (!WRST_n) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      af_q    <= af_d;
    end
  end

  assign W_LEVEL     = level_q;
  assign ALMOST_FULL = af_q;
`else
  assign W_LEVEL     = '0;
  // Legal thresholds are >= 1, so this ties ALMOST_FULL low.
  assign ALMOST_FULL = (AF_THRESH < 1);
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed, table-driven bench for wptr_full_ctrl (ADDR_WIDTH=4, AF_THRESH=12).
// Expectations adapt to whether WPTR_LEVEL_EN is defined.
module tb_wptr_full_ctrl;

`ifdef WPTR_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic       W_CLK;
  logic       WRST_n;
  logic       W_EN;
  logic       CLR_OVF;
  logic [4:0] G_RPTR_SYNC;
  logic       W_ACCEPT;
  logic [3:0] W_ADDR;
  logic [4:0] G_WPTR;
  logic       FULL;
  logic       ALMOST_FULL;
  logic [4:0] W_LEVEL;
  logic       OVERFLOW;

  int checks = 0;
  int errors = 0;

  wptr_full_ctrl #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
    .W_CLK      (W_CLK),
    .WRST_n     (WRST_n),
    .W_EN       (W_EN),
    .CLR_OVF    (CLR_OVF),
    .G_RPTR_SYNC(G_RPTR_SYNC),
    .W_ACCEPT   (W_ACCEPT),
    .W_ADDR     (W_ADDR),
    .G_WPTR     (G_WPTR),
    .FULL       (FULL),
    .ALMOST_FULL(ALMOST_FULL),
    .W_LEVEL    (W_LEVEL),
    .OVERFLOW   (OVERFLOW)
  );

  initial W_CLK = 1'b0;
  always #5 W_CLK = ~W_CLK;

  // acc/addr are checked before the edge; the rest after it.
  typedef struct {
    logic       w_en;
    logic       clr;
    logic [4:0] g_r;
    logic       acc;
    logic [3:0] addr;
    logic [4:0] gw;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at posedge+1; returns at the following posedge+1.
  task automatic step(input string tag, input vec_t v);
    W_EN        = v.w_en;
    CLR_OVF     = v.clr;
    G_RPTR_SYNC = v.g_r;
    @(negedge W_CLK);
    chk({tag, " accept"}, 32'(W_ACCEPT), 32'(v.acc));
    chk({tag, " addr"},   32'(W_ADDR),   32'(v.addr));
    @(posedge W_CLK);
    #1;
    chk({tag, " gwptr"},  32'(G_WPTR),      32'(v.gw));
    chk({tag, " full"},   32'(FULL),        32'(v.full));
    chk({tag, " afull"},  32'(ALMOST_FULL), 32'(v.af));
    chk({tag, " level"},  32'(W_LEVEL),     32'(v.lvl));
    chk({tag, " ovf"},    32'(OVERFLOW),    32'(v.ovf));
    $display("%s: w_en=%0b clr=%0b g_r=%05b -> acc=%0b addr=%0d gw=%05b full=%0b af=%0b lvl=%0d ovf=%0b",
             tag, v.w_en, v.clr, v.g_r, W_ACCEPT, W_ADDR, G_WPTR, FULL, ALMOST_FULL, W_LEVEL, OVERFLOW);
  endtask

  function automatic vec_t mk(input logic w, input logic c, input logic [4:0] gr, input logic a,
                              input logic [3:0] ad, input logic [4:0] gw, input logic f,
                              input logic af, input logic [4:0] lv, input logic o);
    vec_t v;
    v.w_en = w; v.clr = c; v.g_r = gr; v.acc = a; v.addr = ad; v.gw = gw;
    v.full = f; v.af = LVL ? af : 1'b0; v.lvl = LVL ? lv : 5'd0; v.ovf = o;
    return v;
  endfunction

  initial begin
    vec_t v;

    // Fill: 16 writes into an empty FIFO, then full / overflow / read-advance corners.
    for (int k = 0; k < 16; k++)
      tbl[k] = mk(1, 0, 5'd0, 1, 4'(k), gray(k + 1), (k == 15), (k + 1 >= 12), 5'(k + 1), 0);
    tbl[16] = mk(1, 0, 5'b00000, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    tbl[17] = mk(1, 0, 5'b00000, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    tbl[18] = mk(1, 1, 5'b00000, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    tbl[19] = mk(0, 1, 5'b00000, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    tbl[20] = mk(0, 0, 5'b00001, 0, 4'd0, 5'b11000, 0, 1, 5'd15, 0);
    tbl[21] = mk(1, 0, 5'b00001, 1, 4'd0, 5'b11001, 1, 1, 5'd16, 0);

    // Reset state.
    WRST_n = 1'b0; W_EN = 1'b0; CLR_OVF = 1'b0; G_RPTR_SYNC = 5'd0;
    #2;
    chk("rst accept", 32'(W_ACCEPT), 32'd0);
    chk("rst addr",   32'(W_ADDR),   32'd0);
    chk("rst gwptr",  32'(G_WPTR),   32'd0);
    chk("rst full",   32'(FULL),     32'd0);
    chk("rst afull",  32'(ALMOST_FULL), 32'd0);
    chk("rst level",  32'(W_LEVEL),  32'd0);
    chk("rst ovf",    32'(OVERFLOW), 32'd0);
    W_EN = 1'b1;
    #1;
    chk("rst accept follows w_en", 32'(W_ACCEPT), 32'd1);
    W_EN = 1'b0;
    @(posedge W_CLK);
    #1;
    WRST_n = 1'b1;

    for (int i = 0; i < 22; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Read-only step to leave full, then simultaneous write+read across pointer wrap.
    step("rd2", mk(0, 0, gray(2), 0, 4'd1, 5'b11001, 0, 1, 5'd15, 0));
    for (int i = 0; i < 40; i++) begin
      int b;
      int r;
      b = 17 + i;
      r = 2 + i;
      step($sformatf("wrap%0d", i),
           mk(1, 0, gray(r + 1), 1, 4'(b % 16), gray(b + 1), 0, 1, 5'd15, 0));
    end

    // Asynchronous reset with occupancy 9.
    WRST_n = 1'b0;
    #1;
    WRST_n = 1'b1;
    G_RPTR_SYNC = 5'd0;
    for (int k = 0; k < 9; k++)
      step($sformatf("fill%0d", k), mk(1, 0, 5'd0, 1, 4'(k), gray(k + 1), 0, 0, 5'(k + 1), 0));
    #2;
    WRST_n = 1'b0;
    #1;
    chk("arst accept", 32'(W_ACCEPT), 32'd1);
    chk("arst addr",   32'(W_ADDR),   32'd0);
    chk("arst gwptr",  32'(G_WPTR),   32'd0);
    chk("arst full",   32'(FULL),     32'd0);
    chk("arst afull",  32'(ALMOST_FULL), 32'd0);
    chk("arst level",  32'(W_LEVEL),  32'd0);
    chk("arst ovf",    32'(OVERFLOW), 32'd0);
    W_EN = 1'b0;
    @(posedge W_CLK);
    #1;
    WRST_n = 1'b1;
    step("post_rst", mk(1, 0, 5'd0, 1, 4'd0, 5'b00001, 0, 0, 5'd1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
